// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner.
//   state_e : scan FSM states
//   FONT    : active-high g..a segment patterns for hex digits 0..F
//   to_pin  : maps an active-high logical level onto a pin of either polarity
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic to_pin(input logic active, input bit active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-7-segment decoder.
//   nibble  : 4-bit hex value
//   pattern : active-high segments, pattern[6:0] = g..a
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = FONT[nibble];
  end

endmodule

// File: rtl/seg7_scan_n.sv
// Multiplexed scanner for NUM_DIGITS common-anode 7-segment digits.
// Each digit slot is BLANK_TICKS ticks dark followed by ON_TICKS ticks lit;
// the displayed value is captured into shadow registers once per frame.
//   clk, reset  : system clock, synchronous active-high reset
//   value       : hex nibbles, nibble 0 = rightmost digit
//   dp          : decimal point per digit, 1 = lit
//   digit_en    : 1 = digit may light
//   lz_blank    : 1 = blank leading zero digits
//   an          : anode drives, one-hot active while a digit is shown
//   seg         : seg[7] = dp, seg[6:0] = g..a
//   frame_tick  : one-cycle pulse when the frame wraps
module seg7_scan_n
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 100000,
  parameter int ON_TICKS       = 1,
  parameter int BLANK_TICKS    = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_tick
);

  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SLOT_MAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
  localparam int SLOT_W   = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;

  localparam logic [DIV_W-1:0]      DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SLOT_W-1:0]     ON_LAST    = SLOT_W'(ON_TICKS - 1);
  localparam logic [SLOT_W-1:0]     BLANK_LAST = SLOT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam state_e                ST_RESET   = (BLANK_TICKS > 0) ? ST_BLANK : ST_SHOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
  localparam logic [7:0]            SEG_OFF    = {8{SEG_ACTIVE_LOW != 0}};

  logic [DIV_W-1:0]      div_q, div_d;
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [4*NUM_DIGITS-1:0] sh_value_q, sh_value_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0] sh_en_q, sh_en_d;
  logic                  sh_lz_q, sh_lz_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  tick;
  logic                  wrap;
  logic                  zero_above;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_en;
  logic                  cur_lzb;
  logic                  lit;
  logic [6:0]            pattern;
  logic [NUM_DIGITS-1:0] an_raw;
  logic [7:0]            seg_raw;

  // Divider, scan FSM and frame-wrap shadow capture.
  always_comb begin
    tick       = (div_q == DIV_LAST);
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    state_d    = state_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    wrap       = 1'b0;
    sh_value_d = sh_value_q;
    sh_dp_d    = sh_dp_q;
    sh_en_d    = sh_en_q;
    sh_lz_d    = sh_lz_q;

    if (tick) begin
      case (state_q)
        ST_BLANK: begin
          if (slot_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        ST_SHOW: begin
          if (slot_q == ON_LAST) begin
            state_d = (BLANK_TICKS == 0) ? ST_SHOW : ST_BLANK;
            slot_d  = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      endcase
    end

    if (wrap) begin
      sh_value_d = value;
      sh_dp_d    = dp;
      sh_en_d    = digit_en;
      sh_lz_d    = lz_blank;
    end
  end

  // Leading-zero mask over the shadow word, scanning from the top nibble down.
  // Uses the post-edge shadow so a digit 0 shown right at a wrap sees the new frame.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (sh_value_d[4*i +: 4] == 4'h0);
      lz_mask[i] = sh_lz_d && zero_above;
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_lzb = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == idx_d) begin
        cur_nib = sh_value_d[4*k +: 4];
        cur_dp  = sh_dp_d[k];
        cur_en  = sh_en_d[k];
        cur_lzb = lz_mask[k];
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble  (cur_nib),
    .pattern (pattern)
  );

  // Output pins are registered from the post-edge scan position so they
  // change on the same tick edge as the FSM.
  always_comb begin
    an_raw  = '0;
    seg_raw = '0;
    lit     = (state_d == ST_SHOW) && cur_en && !cur_lzb;
    if (lit) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        an_raw[k] = (IDX_W'(k) == idx_d);
      end
      seg_raw = {cur_dp, pattern};
    end

    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        an_d[k] = to_pin(an_raw[k], AN_ACTIVE_LOW != 0);
      end
      for (int unsigned k = 0; k < 8; k++) begin
        seg_d[k] = to_pin(seg_raw[k], SEG_ACTIVE_LOW != 0);
      end
    end
    frame_tick_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      state_q      <= ST_RESET;
      idx_q        <= '0;
      slot_q       <= '0;
      sh_value_q   <= '0;
      sh_dp_q      <= '0;
      sh_en_q      <= '0;
      sh_lz_q      <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      slot_q       <= slot_d;
      sh_value_q   <= sh_value_d;
      sh_dp_q      <= sh_dp_d;
      sh_en_q      <= sh_en_d;
      sh_lz_q      <= sh_lz_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_n.sv
// Bench for seg7_scan_n with 4 digits, CLK_DIV=4, one blank and one on tick
// per slot, active-low pins. Expected pin values derive from the number of
// clock edges since reset: slot = edges/4, frame = 8 slots = 32 edges.
module tb_seg7_scan_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_blank = 1'b0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  seg7_scan_n #(
    .NUM_DIGITS     (4),
    .CLK_DIV        (4),
    .ON_TICKS       (1),
    .BLANK_TICKS    (1),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp         (dp),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned e = 0;
  bit          started = 1'b0;

  logic [15:0] m_value = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_en = '0;
  logic        m_lz = 1'b0;
  logic [6:0]  font [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic        exp_ft;

  function automatic void model_out(input int unsigned ev, output logic [3:0] ea,
                                    output logic [7:0] es, output logic ef);
    int unsigned p = (ev / 4) % 8;
    int unsigned d;
    logic [3:0]  nib;
    logic [7:0]  raw;
    ea = 4'hF;
    es = 8'hFF;
    ef = (ev != 0) && (ev % 32 == 0);
    if (p % 2 == 1) begin
      d   = (p - 1) / 2;
      nib = 4'(m_value >> (4 * d));
      if (m_en[d] && !(m_lz && d > 0 && (m_value >> (4 * d)) == 0)) begin
        ea  = ~(4'b0001 << d);
        raw = {m_dp[d], font[nib]};
        es  = ~raw;
      end
    end
  endfunction

  // Model time base plus the every-cycle comparison.
  always @(posedge clk) begin
    if (reset) begin
      e       = 0;
      m_value = '0;
      m_dp    = '0;
      m_en    = '0;
      m_lz    = 1'b0;
      started = 1'b1;
    end else if (started) begin
      e++;
      if (e % 32 == 0) begin
        m_value = value;
        m_dp    = dp;
        m_en    = digit_en;
        m_lz    = lz_blank;
      end
    end
    #1;
    if (started) begin
      model_out(e, exp_an, exp_seg, exp_ft);
      vectors++;
      if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
        miscompares++;
        $display("FAIL model e=%0d: an=%h seg=%h ft=%b, expected an=%h seg=%h ft=%b",
                 e, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] xa, input logic [7:0] xs,
                     input logic xf);
    vectors++;
    if (an !== xa || seg !== xs || frame_tick !== xf) begin
      miscompares++;
      $display("FAIL %s: an=%h seg=%h ft=%b, expected an=%h seg=%h ft=%b",
               name, an, seg, frame_tick, xa, xs, xf);
    end
  endtask

  task automatic step_to(input int unsigned target, input string name);
    int guard = 0;
    while (e != target && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (e != target) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: edge count %0d, expected %0d", name, e, target);
    end
  endtask

  // Check digit d shown in frame k (or dark: pass an=F seg=FF).
  task automatic show(input int unsigned k, input int unsigned d, input string name,
                      input logic [3:0] xa, input logic [7:0] xs);
    step_to(32 * k + 8 * d + 5, name);
    chk(name, xa, xs, 1'b0);
  endtask

  task automatic blank(input int unsigned k, input int unsigned d, input string name);
    step_to(32 * k + 8 * d + 1, name);
    chk(name, 4'hF, 8'hFF, 1'b0);
  endtask

  initial begin
    // 1: reset held, then first blank interval and dark frame 0
    repeat (10) begin
      @(negedge clk);
      chk("reset_hold", 4'hF, 8'hFF, 1'b0);
    end
    reset = 1'b0;
    step_to(3, "first_blank");
    chk("first_blank", 4'hF, 8'hFF, 1'b0);
    show(0, 0, "frame0_d0_dark", 4'hF, 8'hFF);

    // 2: basic hex display
    value    = 16'h12AF;
    dp       = 4'h0;
    digit_en = 4'hF;
    lz_blank = 1'b0;
    step_to(32, "wrap1");
    chk("wrap1_tick", 4'hF, 8'hFF, 1'b1);
    step_to(33, "wrap1_end");
    chk("wrap1_end", 4'hF, 8'hFF, 1'b0);
    show(1, 0, "hex_d0", 4'hE, 8'h8E);
    blank(1, 1, "hex_b1");
    show(1, 1, "hex_d1", 4'hD, 8'h88);
    blank(1, 2, "hex_b2");
    show(1, 2, "hex_d2", 4'hB, 8'hA4);
    blank(1, 3, "hex_b3");
    show(1, 3, "hex_d3", 4'h7, 8'hF9);

    // 3: leading-zero blanking
    lz_blank = 1'b1;
    value    = 16'h0070;
    show(2, 0, "lz70_d0", 4'hE, 8'hC0);
    show(2, 1, "lz70_d1", 4'hD, 8'hF8);
    show(2, 2, "lz70_d2", 4'hF, 8'hFF);
    show(2, 3, "lz70_d3", 4'hF, 8'hFF);
    value = 16'h0000;
    show(3, 0, "lz0_d0", 4'hE, 8'hC0);
    show(3, 1, "lz0_d1", 4'hF, 8'hFF);
    show(3, 2, "lz0_d2", 4'hF, 8'hFF);
    show(3, 3, "lz0_d3", 4'hF, 8'hFF);

    // 4: decimal point and disabled digit
    value    = 16'h0005;
    dp       = 4'b0001;
    digit_en = 4'b1101;
    lz_blank = 1'b0;
    show(4, 0, "dp_d0", 4'hE, 8'h12);
    show(4, 1, "en_d1", 4'hF, 8'hFF);
    show(4, 2, "en_d2", 4'hB, 8'hC0);
    show(4, 3, "en_d3", 4'h7, 8'hC0);

    // 5: mid-frame update is deferred to the next wrap
    value    = 16'h1111;
    dp       = 4'h0;
    digit_en = 4'hF;
    show(5, 0, "tear_d0", 4'hE, 8'hF9);
    step_to(170, "tear_change");
    value = 16'h2222;
    show(5, 1, "tear_d1", 4'hD, 8'hF9);
    show(5, 2, "tear_d2", 4'hB, 8'hF9);
    show(5, 3, "tear_d3", 4'h7, 8'hF9);
    step_to(192, "wrap6");
    chk("wrap6_tick", 4'hF, 8'hFF, 1'b1);
    step_to(193, "wrap6_end");
    chk("wrap6_end", 4'hF, 8'hFF, 1'b0);
    show(6, 0, "new_d0", 4'hE, 8'hA4);
    show(6, 1, "new_d1", 4'hD, 8'hA4);
    show(6, 2, "new_d2", 4'hB, 8'hA4);
    show(6, 3, "new_d3", 4'h7, 8'hA4);

    // 6: reset during digit 2 SHOW restarts the scan with cleared shadow
    show(7, 2, "pre_reset_d2", 4'hB, 8'hA4);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_1", 4'hF, 8'hFF, 1'b0);
    @(negedge clk);
    chk("midreset_2", 4'hF, 8'hFF, 1'b0);
    reset = 1'b0;
    blank(0, 0, "restart_b0");
    show(0, 0, "restart_d0_dark", 4'hF, 8'hFF);
    show(0, 1, "restart_d1_dark", 4'hF, 8'hFF);
    step_to(32, "restart_wrap");
    chk("restart_wrap_tick", 4'hF, 8'hFF, 1'b1);
    show(1, 0, "restart_f1_d0", 4'hE, 8'hA4);
    show(1, 3, "restart_f1_d3", 4'h7, 8'hA4);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
